// File: rtl/lbm_sweep_ctrl.sv
// lbm_sweep_ctrl: raster sweep sequencer for LBM collide/stream phases with ping-pong buffer swap
module lbm_sweep_ctrl #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int STEP_WIDTH = 16,
  parameter int ADDR_W = $clog2(GRID_W*GRID_H)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_WIDTH-1:0]     num_steps,
  input  logic                      cell_ready,
  input  logic                      pe_idle,
  output logic                      cell_valid,
  output logic [ADDR_W-1:0]         cell_addr,
  output logic [$clog2(GRID_H)-1:0] row,
  output logic [$clog2(GRID_W)-1:0] col,
  output logic                      is_boundary,
  output logic [1:0]                phase,
  output logic                      buf_sel,
  output logic                      busy,
  output logic [STEP_WIDTH-1:0]     step_count,
  output logic                      done
);
  localparam int RW = $clog2(GRID_H);
  localparam int CW = $clog2(GRID_W);
  typedef enum logic [2:0] {IDLE, COLLIDE, C_DRAIN, STREAM, S_DRAIN, SWAP, DONE} state_t;
  state_t state, state_nx;
  logic [STEP_WIDTH-1:0] steps_q, step_nx;
  logic hs, last, kill, go;
  assign hs = cell_valid && cell_ready;
  assign last = row == RW'(GRID_H-1) && col == CW'(GRID_W-1);
  assign kill = abort && state != IDLE;
  assign go = state == IDLE && start;
  assign step_nx = step_count + STEP_WIDTH'(1);
  assign cell_valid = state == COLLIDE || state == STREAM;
  assign cell_addr = {row, col};
  assign is_boundary = row == '0 || row == RW'(GRID_H-1) || col == '0 || col == CW'(GRID_W-1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign phase = (state == COLLIDE || state == C_DRAIN) ? 2'd1 :
                 (state == STREAM || state == S_DRAIN)  ? 2'd2 :
                 (state == SWAP)                        ? 2'd3 : 2'd0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = num_steps == '0 ? DONE : COLLIDE;
      COLLIDE: if (hs && last) state_nx = C_DRAIN;
      C_DRAIN: if (pe_idle) state_nx = STREAM;
      STREAM:  if (hs && last) state_nx = S_DRAIN;
      S_DRAIN: if (pe_idle) state_nx = SWAP;
      SWAP:    state_nx = step_nx == steps_q ? DONE : COLLIDE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      steps_q <= '0;
      step_count <= '0;
      buf_sel <= 1'b0;
    end else begin
      state <= state_nx;
      if (kill || go || (hs && last)) begin
        row <= '0;
        col <= '0;
      end else if (hs) begin
        col <= col + CW'(1);
        if (col == CW'(GRID_W-1)) row <= row + RW'(1);
      end
      if (go) begin
        steps_q <= num_steps;
        step_count <= '0;
      end
      if (state == SWAP && !abort) begin
        buf_sel <= ~buf_sel;
        step_count <= step_nx;
      end
    end
endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// tb_lbm_sweep_ctrl: scoreboard bench for the LBM sweep sequencer
module tb_lbm_sweep_ctrl;
  localparam int W = 16;
  localparam int H = 16;
  typedef struct {int ph; int a;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, cell_ready = 1, pe_idle = 1;
  logic [15:0] num_steps = '0;
  logic cell_valid, is_boundary, buf_sel, busy, done;
  logic [7:0] cell_addr;
  logic [3:0] row, col;
  logic [1:0] phase;
  logic [15:0] step_count;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, done_cnt = 0, swap_cnt = 0, n, d0, s0;
  bit mon_en = 0, exp_buf = 0;
  lbm_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_steps(num_steps),
    .cell_ready(cell_ready), .pe_idle(pe_idle), .cell_valid(cell_valid), .cell_addr(cell_addr),
    .row(row), .col(col), .is_boundary(is_boundary), .phase(phase), .buf_sel(buf_sel),
    .busy(busy), .step_count(step_count), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_step(input int steps);
    for (int s = 0; s < steps; s++)
      for (int p = 1; p <= 2; p++)
        for (int a = 0; a < W*H; a++) sb.push_back('{p, a});
  endtask
  task automatic launch(input int steps);
    num_steps = 16'(steps);
    push_step(steps);
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic run_to_done(input bit rnd, output int cyc);
    cyc = 0;
    while (!done && cyc < 20000) begin
      cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      cyc++;
    end
    cell_ready = 1;
    chk("done_seen", done, 1);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, cell_valid, 0);
    chk({tag, "_addr"}, cell_addr, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_bnd"}, is_boundary, 1);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_buf"}, buf_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_steps"}, step_count, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  initial begin
    bit hold_p = 0;
    logic [7:0] hold_a;
    int bcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) hold_p = 0;
      else begin
        if (done) done_cnt++;
        if (phase == 2'd3) swap_cnt++;
        if (hold_p) chk("hold_addr", cell_addr, hold_a);
        hold_p = cell_valid && !cell_ready;
        hold_a = cell_addr;
        if (cell_valid && cell_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("phase", phase, e.ph);
            chk("addr", cell_addr, e.a);
            chk("row", row, e.a / W);
            chk("col", col, e.a % W);
            chk("boundary", is_boundary, (e.a / W == 0 || e.a / W == H-1 || e.a % W == 0 || e.a % W == W-1));
            if (e.a == 0) bcnt = 0;
            bcnt += is_boundary;
            if (e.a == W*H-1) chk("bnd_count", bcnt, 60);
          end
        end
      end
    end
  end
  initial begin
    #3 reset_vals("rst");
    #9 rst_n = 1;
    mon_en = 1;
    tick;
    // single step, full throughput
    launch(1);
    chk("first_valid", cell_valid, 1);
    chk("first_addr", cell_addr, 0);
    run_to_done(0, n);
    chk("done_lat", n, 515);
    exp_buf = ~exp_buf;
    chk("t1_buf", buf_sel, exp_buf);
    chk("t1_steps", step_count, 1);
    chk("t1_busy_done", busy, 1);
    tick;
    chk("t1_busy_off", busy, 0);
    chk("t1_done_off", done, 0);
    chk("t1_sb_empty", sb.size(), 0);
    // random backpressure
    launch(1);
    run_to_done(1, n);
    exp_buf = ~exp_buf;
    chk("t2_buf", buf_sel, exp_buf);
    tick;
    chk("t2_sb_empty", sb.size(), 0);
    // drain hold with Start ignored while busy
    pe_idle = 0;
    launch(1);
    n = 0;
    while (!(phase == 2'd1 && !cell_valid) && n < 2000) begin tick; n++; end
    start = 1;
    num_steps = 16'd7;
    for (int i = 0; i < 10; i++) begin
      chk("c_drain_hold", {phase, cell_valid}, {2'd1, 1'b0});
      tick;
    end
    chk("c_drain_still", {phase, cell_valid}, {2'd1, 1'b0});
    start = 0;
    pe_idle = 1;
    tick;
    chk("stream_start", {phase, cell_valid, cell_addr}, {2'd2, 1'b1, 8'd0});
    run_to_done(0, n);
    exp_buf = ~exp_buf;
    chk("t3_steps", step_count, 1);
    chk("t3_buf", buf_sel, exp_buf);
    tick;
    // three steps
    d0 = done_cnt;
    s0 = swap_cnt;
    launch(3);
    run_to_done(0, n);
    tick;
    exp_buf = ~exp_buf;
    chk("t4_swaps", swap_cnt - s0, 3);
    chk("t4_dones", done_cnt - d0, 1);
    chk("t4_buf", buf_sel, exp_buf);
    chk("t4_steps", step_count, 3);
    chk("t4_sb_empty", sb.size(), 0);
    // zero steps
    launch(0);
    chk("t5_done", done, 1);
    chk("t5_valid", cell_valid, 0);
    chk("t5_steps", step_count, 0);
    chk("t5_buf", buf_sel, exp_buf);
    tick;
    chk("t5_busy_off", busy, 0);
    // abort at stream addr 100 of second step
    launch(2);
    n = 0;
    while (!(step_count == 1 && phase == 2'd2 && cell_addr == 8'd100) && n < 5000) begin tick; n++; end
    chk("t6_reach", {phase, cell_addr}, {2'd2, 8'd100});
    exp_buf = ~exp_buf;
    d0 = done_cnt;
    abort = 1;
    tick;
    abort = 0;
    sb.delete();
    chk("t6_valid", cell_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_phase", phase, 0);
    chk("t6_buf", buf_sel, exp_buf);
    chk("t6_steps", step_count, 1);
    chk("t6_addr", cell_addr, 0);
    tick;
    chk("t6_no_done", done_cnt - d0, 0);
    launch(1);
    chk("t6_restart", {phase, cell_valid, cell_addr}, {2'd1, 1'b1, 8'd0});
    run_to_done(0, n);
    exp_buf = ~exp_buf;
    chk("t6_buf2", buf_sel, exp_buf);
    tick;
    // async reset mid-collide
    launch(1);
    for (int i = 0; i < 40; i++) tick;
    #2 rst_n = 0;
    mon_en = 0;
    #1 reset_vals("arst");
    sb.delete();
    tick;
    rst_n = 1;
    mon_en = 1;
    tick;
    chk("post_rst_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
